// File: rtl/alu_ctrl_fsm.sv
// ============================================================================
// alu_ctrl_fsm
// ----------------------------------------------------------------------------
// Control unit of the 8-bit accumulator CPU. Steps through fetch, decode and
// execute, and drives the ALU op code, the register load enables and the
// memory strobes for each instruction. This is a Moore machine, except that
// the load enables which complete a memory access are qualified by mem_ready_i.
//
// Parameters
//   MEM_WAIT_MAX  Maximum number of cycles a memory strobe waits for
//                 mem_ready_i. When the count reaches this value the FSM
//                 halts with a bus error. A value of 0 disables the
//                 timeout. Legal range is 0..255.
//
// Build option
//   SINGLE_STEP_EN  When defined, the FSM enters STEP_WAIT after every
//                   instruction and before the first fetch. A one-cycle
//                   step_i pulse then releases the next instruction.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   run_i        leave IDLE and start fetching (sampled only in IDLE)
//   step_i       single-step pulse (used only with SINGLE_STEP_EN)
//   opcode_i     IR[7:4]
//   flags_i      registered flags, [0] zero, [1] carry
//   mem_ready_i  memory completes the current access this cycle
//   alu_op_o     000 ADD, 001 SUB, 010 pass
//   acc_ld_o     load ACC from the ALU result
//   flags_ld_o   load the flags register from the ALU flags
//   pc_inc_o     PC <= PC + 1
//   pc_ld_o      PC <= MDR
//   mar_ld_o     load MAR
//   mar_sel_o    MAR source, 0 = PC, 1 = MDR
//   mem_rd_o     memory read strobe
//   mem_wr_o     memory write strobe (write data is ACC)
//   mdr_ld_o     MDR <= memory data (mem_rd_o & mem_ready_i)
//   ir_ld_o      IR <= memory data
//   halted_o     FSM is in HALT
//   err_o        sticky bus-timeout error
//   state_o      current state encoding (debug)
// ============================================================================
module alu_ctrl_fsm #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       run_i,
    input  logic       step_i,
    input  logic [3:0] opcode_i,
    input  logic [1:0] flags_i,
    input  logic       mem_ready_i,
    output logic [2:0] alu_op_o,
    output logic       acc_ld_o,
    output logic       flags_ld_o,
    output logic       pc_inc_o,
    output logic       pc_ld_o,
    output logic       mar_ld_o,
    output logic       mar_sel_o,
    output logic       mem_rd_o,
    output logic       mem_wr_o,
    output logic       mdr_ld_o,
    output logic       ir_ld_o,
    output logic       halted_o,
    output logic       err_o,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FA        = 4'd1,
        S_FM        = 4'd2,
        S_DEC       = 4'd3,
        S_SKIP      = 4'd4,
        S_OA        = 4'd5,
        S_OM        = 4'd6,
        S_JMP       = 4'd7,
        S_EA        = 4'd8,
        S_EM        = 4'd9,
        S_EX        = 4'd10,
        S_WR        = 4'd11,
        S_HALT      = 4'd12
`ifdef SINGLE_STEP_EN
        ,
        S_STEP_WAIT = 4'd13
`endif
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_LDA = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_PASS = 3'b010;

    localparam bit         TIMEOUT_EN = (MEM_WAIT_MAX != 0);
    localparam logic [7:0] WAIT_MAX   = MEM_WAIT_MAX[7:0];

    // Where an instruction goes once it has finished: straight to the next
    // fetch, or into the single-step hold.
`ifdef SINGLE_STEP_EN
    localparam state_t NEXT_INSTR = S_STEP_WAIT;
`else
    localparam state_t NEXT_INSTR = S_FA;
    logic unused_step;
    assign unused_step = step_i;
`endif

    state_t     state_q;
    state_t     state_d;
    logic [7:0] wait_cnt_q;
    logic       err_q;
    logic       err_set;
    logic       timeout;
    logic       mem_rd;
    logic       mem_wr;

    // The timeout only matters in a strobe state; the counter is cleared on
    // every state change, so a stale count never leaks into the next access.
    assign timeout = TIMEOUT_EN && (wait_cnt_q == WAIT_MAX);

    // State register and sticky error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | err_set;
        end
    end

    // Memory wait counter. It counts cycles a strobe is held without ready,
    // and saturates so that a disabled timeout cannot wrap it around.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= 8'd0;
        end else if ((state_d != state_q) || mem_ready_i) begin
            wait_cnt_q <= 8'd0;
        end else if ((mem_rd || mem_wr) && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    // Next-state and output decode. Every output is driven from the state
    // alone, except the enables that complete a memory access on mem_ready_i.
    always_comb begin
        state_d    = state_q;
        alu_op_o   = ALU_ADD;
        acc_ld_o   = 1'b0;
        flags_ld_o = 1'b0;
        pc_inc_o   = 1'b0;
        pc_ld_o    = 1'b0;
        mar_ld_o   = 1'b0;
        mar_sel_o  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_ld_o    = 1'b0;
        err_set    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = NEXT_INSTR;
            end

            S_FA: begin
                mar_ld_o = 1'b1;
                state_d  = S_FM;
            end

            S_FM: begin
                if (timeout) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ready_i) begin
                        ir_ld_o  = 1'b1;
                        pc_inc_o = 1'b1;
                        state_d  = S_DEC;
                    end
                end
            end

            // Opcodes 8..E are illegal and fall into the NOP default.
            S_DEC: begin
                case (opcode_i)
                    OP_ADD, OP_SUB, OP_LDA, OP_STA, OP_JMP: state_d = S_OA;
                    OP_JZ:  state_d = flags_i[0] ? S_OA : S_SKIP;
                    OP_JC:  state_d = flags_i[1] ? S_OA : S_SKIP;
                    OP_HLT: state_d = S_HALT;
                    default: state_d = NEXT_INSTR;
                endcase
            end

            // A branch that is not taken still has to step over its operand.
            S_SKIP: begin
                pc_inc_o = 1'b1;
                state_d  = NEXT_INSTR;
            end

            S_OA: begin
                mar_ld_o = 1'b1;
                state_d  = S_OM;
            end

            S_OM: begin
                if (timeout) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ready_i) begin
                        pc_inc_o = 1'b1;
                        if ((opcode_i == OP_JMP) || (opcode_i == OP_JZ) ||
                            (opcode_i == OP_JC))
                            state_d = S_JMP;
                        else
                            state_d = S_EA;
                    end
                end
            end

            S_JMP: begin
                pc_ld_o = 1'b1;
                state_d = NEXT_INSTR;
            end

            // The operand byte now in MDR becomes the data address.
            S_EA: begin
                mar_sel_o = 1'b1;
                mar_ld_o  = 1'b1;
                state_d   = (opcode_i == OP_STA) ? S_WR : S_EM;
            end

            S_EM: begin
                if (timeout) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    mem_rd = 1'b1;
                    if (mem_ready_i) state_d = S_EX;
                end
            end

            S_EX: begin
                case (opcode_i)
                    OP_SUB:  alu_op_o = ALU_SUB;
                    OP_LDA:  alu_op_o = ALU_PASS;
                    default: alu_op_o = ALU_ADD;
                endcase
                acc_ld_o   = 1'b1;
                flags_ld_o = 1'b1;
                state_d    = NEXT_INSTR;
            end

            S_WR: begin
                if (timeout) begin
                    err_set = 1'b1;
                    state_d = S_HALT;
                end else begin
                    mem_wr = 1'b1;
                    if (mem_ready_i) state_d = NEXT_INSTR;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

`ifdef SINGLE_STEP_EN
            S_STEP_WAIT: begin
                if (step_i) state_d = S_FA;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_rd_o = mem_rd;
    assign mem_wr_o = mem_wr;
    assign mdr_ld_o = mem_rd & mem_ready_i;
    assign halted_o = (state_q == S_HALT);
    assign err_o    = err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// ============================================================================
// tb_alu_ctrl_fsm
// ----------------------------------------------------------------------------
// Directed testbench for alu_ctrl_fsm in its default build (single-step
// disabled). Around the FSM it models a small datapath: PC, MAR, MDR, IR,
// ACC, flags, a 256-byte memory with a programmable ready delay, and the ALU.
// Small programs run to HALT, and the results are compared with
// hand-computed values. MEM_WAIT_MAX is set to 4 so that the bus-timeout
// path can be reached.
// ============================================================================
module tb_alu_ctrl_fsm;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic       run_i = 1'b0;
    logic       step_i = 1'b0;
    logic [3:0] opcode_i;
    logic [1:0] flags_i;
    logic       mem_ready_i;
    logic [2:0] alu_op_o;
    logic       acc_ld_o;
    logic       flags_ld_o;
    logic       pc_inc_o;
    logic       pc_ld_o;
    logic       mar_ld_o;
    logic       mar_sel_o;
    logic       mem_rd_o;
    logic       mem_wr_o;
    logic       mdr_ld_o;
    logic       ir_ld_o;
    logic       halted_o;
    logic       err_o;
    logic [3:0] state_o;

    int tests_run = 0;
    int failures  = 0;

    alu_ctrl_fsm #(.MEM_WAIT_MAX(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .run_i       (run_i),
        .step_i      (step_i),
        .opcode_i    (opcode_i),
        .flags_i     (flags_i),
        .mem_ready_i (mem_ready_i),
        .alu_op_o    (alu_op_o),
        .acc_ld_o    (acc_ld_o),
        .flags_ld_o  (flags_ld_o),
        .pc_inc_o    (pc_inc_o),
        .pc_ld_o     (pc_ld_o),
        .mar_ld_o    (mar_ld_o),
        .mar_sel_o   (mar_sel_o),
        .mem_rd_o    (mem_rd_o),
        .mem_wr_o    (mem_wr_o),
        .mdr_ld_o    (mdr_ld_o),
        .ir_ld_o     (ir_ld_o),
        .halted_o    (halted_o),
        .err_o       (err_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    // All control outputs packed together so that a reset check is one compare.
    logic [15:0] all_out;
    assign all_out = {alu_op_o, acc_ld_o, flags_ld_o, pc_inc_o, pc_ld_o,
                      mar_ld_o, mar_sel_o, mem_rd_o, mem_wr_o, mdr_ld_o,
                      ir_ld_o, halted_o, err_o};

    // Datapath environment.
    logic [7:0] prog [256];
    logic [7:0] mem  [256];
    logic [7:0] pc, mar, mdr, ir, acc;
    logic [1:0] flags;
    logic [7:0] wcnt;
    logic [7:0] ready_delay = 8'd0;
    logic       stuck_low = 1'b0;
    logic [8:0] alu_res;

    int n_acc_ld, n_flags_ld, n_pc_ld, n_mdr_ld, n_ir_ld, n_mem_rd, n_mem_wr;
    int n_bad_alu, n_bad_mdr;

    assign opcode_i    = ir[7:4];
    assign flags_i     = flags;
    assign mem_ready_i = !stuck_low && (mem_rd_o || mem_wr_o) && (wcnt == ready_delay);

    // The ALU: x is ACC, y is MDR. Bit 8 is the carry (the borrow for SUB).
    always_comb begin
        alu_res = {1'b0, acc};
        case (alu_op_o)
            3'b000:  alu_res = {1'b0, acc} + {1'b0, mdr};
            3'b001:  alu_res = {1'b0, acc} - {1'b0, mdr};
            3'b010:  alu_res = {1'b0, mdr};
            default: alu_res = {1'b0, acc};
        endcase
    end

    // Registers, memory, ready generator and event counters. The memory is
    // loaded from prog while reset is held.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc <= 8'd0; mar <= 8'd0; mdr <= 8'd0; ir <= 8'd0;
            acc <= 8'd0; flags <= 2'd0; wcnt <= 8'd0;
            for (int i = 0; i < 256; i++) mem[i] <= prog[i];
            n_acc_ld <= 0; n_flags_ld <= 0; n_pc_ld <= 0; n_mdr_ld <= 0;
            n_ir_ld <= 0; n_mem_rd <= 0; n_mem_wr <= 0;
            n_bad_alu <= 0; n_bad_mdr <= 0;
        end else begin
            if (mar_ld_o) mar <= mar_sel_o ? mdr : pc;
            if (mdr_ld_o) mdr <= mem[mar];
            if (ir_ld_o)  ir  <= mem[mar];
            if (pc_ld_o) pc <= mdr;
            else if (pc_inc_o) pc <= pc + 8'd1;
            if (mem_wr_o && mem_ready_i) mem[mar] <= acc;
            if (acc_ld_o) acc <= alu_res[7:0];
            if (flags_ld_o) flags <= {alu_res[8], alu_res[7:0] == 8'd0};
            if ((mem_rd_o || mem_wr_o) && !mem_ready_i) wcnt <= wcnt + 8'd1;
            else wcnt <= 8'd0;
            n_acc_ld   <= n_acc_ld   + int'(acc_ld_o);
            n_flags_ld <= n_flags_ld + int'(flags_ld_o);
            n_pc_ld    <= n_pc_ld    + int'(pc_ld_o);
            n_mdr_ld   <= n_mdr_ld   + int'(mdr_ld_o);
            n_ir_ld    <= n_ir_ld    + int'(ir_ld_o);
            n_mem_rd   <= n_mem_rd   + int'(mem_rd_o);
            n_mem_wr   <= n_mem_wr   + int'(mem_wr_o);
            if (state_o != 4'd10 && alu_op_o != 3'b000) n_bad_alu <= n_bad_alu + 1;
            if (mdr_ld_o != (mem_rd_o & mem_ready_i)) n_bad_mdr <= n_bad_mdr + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 8'h00;
    endtask

    // Reset with the given memory behaviour, then raise run_i.
    task automatic apply_stimulus(input logic [7:0] delay, input bit stuck);
        run_i       = 1'b0;
        step_i      = 1'b0;
        ready_delay = delay;
        stuck_low   = stuck;
        rst_ni      = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        run_i  = 1'b1;
    endtask

    // Count cycles from the first FA until halted_o, with bounded waits.
    task automatic run_to_halt(output int cycles);
        int guard;
        guard = 0;
        while (state_o != 4'd1 && guard < 20) begin
            @(posedge clk_i); #1; guard++;
        end
        cycles = 0;
        while (!halted_o && cycles < 300) begin
            @(posedge clk_i); #1; cycles++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int guard;

        // Reset state.
        clear_prog();
        #2 rst_ni = 1'b0;
        #1;
        check_output("reset_state", 32'(state_o), 32'd0);
        check_output("reset_outputs", 32'(all_out), 32'd0);
        repeat (3) @(posedge clk_i);
        #1;
        check_output("reset_hold_outputs", 32'(all_out), 32'd0);

        // LDA 0x10; ADD 0x11; STA 0x12; HLT.
        clear_prog();
        prog[0] = 8'h30; prog[1] = 8'h10; prog[2] = 8'h10; prog[3] = 8'h11;
        prog[4] = 8'h40; prog[5] = 8'h12; prog[6] = 8'hF0;
        prog[8'h10] = 8'h05; prog[8'h11] = 8'h07;
        apply_stimulus(8'd0, 1'b0);
        run_to_halt(cyc);
        check_output("p1_cycles", 32'(cyc), 32'd26);
        check_output("p1_mem12", 32'(mem[8'h12]), 32'h0C);
        check_output("p1_acc", 32'(acc), 32'h0C);
        check_output("p1_err", 32'(err_o), 32'd0);
        check_output("p1_acc_ld_count", 32'(n_acc_ld), 32'd2);
        check_output("p1_mem_wr_count", 32'(n_mem_wr), 32'd1);
        check_output("p1_alu_op_outside_ex", 32'(n_bad_alu), 32'd0);
        run_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        check_output("p1_halt_absorbing", 32'(state_o), 32'd12);
        check_output("p1_halt_strobes", 32'({mem_rd_o, mem_wr_o, mar_ld_o}), 32'd0);

        // LDA 0x30; SUB 0x30 (zero); JZ 0x40 taken; HLT at 0x40.
        clear_prog();
        prog[0] = 8'h30; prog[1] = 8'h30; prog[2] = 8'h20; prog[3] = 8'h30;
        prog[4] = 8'h60; prog[5] = 8'h40; prog[8'h30] = 8'h20; prog[8'h40] = 8'hF0;
        apply_stimulus(8'd0, 1'b0);
        run_to_halt(cyc);
        check_output("p2_cycles", 32'(cyc), 32'd25);
        check_output("p2_flags", 32'(flags), 32'b01);
        check_output("p2_flags_ld_count", 32'(n_flags_ld), 32'd2);
        check_output("p2_pc_ld_count", 32'(n_pc_ld), 32'd1);
        check_output("p2_pc", 32'(pc), 32'h41);

        // LDA 0x31 (non-zero); JZ and JC both not taken; HLT at 6.
        clear_prog();
        prog[0] = 8'h30; prog[1] = 8'h31; prog[2] = 8'h60; prog[3] = 8'h40;
        prog[4] = 8'h70; prog[5] = 8'h40; prog[6] = 8'hF0;
        prog[8'h31] = 8'h05; prog[8'h40] = 8'hF0;
        apply_stimulus(8'd0, 1'b0);
        run_to_halt(cyc);
        check_output("p3_cycles", 32'(cyc), 32'd19);
        check_output("p3_pc_ld_count", 32'(n_pc_ld), 32'd0);
        check_output("p3_pc", 32'(pc), 32'h07);

        // LDA 0x32 (FF); ADD 0x33 (02) sets carry; JC 0x40 taken.
        clear_prog();
        prog[0] = 8'h30; prog[1] = 8'h32; prog[2] = 8'h10; prog[3] = 8'h33;
        prog[4] = 8'h70; prog[5] = 8'h40;
        prog[8'h32] = 8'hFF; prog[8'h33] = 8'h02; prog[8'h40] = 8'hF0;
        apply_stimulus(8'd0, 1'b0);
        run_to_halt(cyc);
        check_output("p4_cycles", 32'(cyc), 32'd25);
        check_output("p4_acc", 32'(acc), 32'h01);
        check_output("p4_flags", 32'(flags), 32'b10);
        check_output("p4_pc", 32'(pc), 32'h41);

        // NOP; illegal 0x9; JMP 0x20; HLT at 0x20.
        clear_prog();
        prog[0] = 8'h00; prog[1] = 8'h90; prog[2] = 8'h50; prog[3] = 8'h20;
        prog[8'h20] = 8'hF0;
        apply_stimulus(8'd0, 1'b0);
        run_to_halt(cyc);
        check_output("p5_cycles", 32'(cyc), 32'd15);
        check_output("p5_pc", 32'(pc), 32'h21);
        check_output("p5_ir", 32'(ir), 32'hF0);

        // ADD 0x11; HLT with three wait cycles on every access.
        clear_prog();
        prog[0] = 8'h10; prog[1] = 8'h11; prog[2] = 8'hF0; prog[8'h11] = 8'h07;
        apply_stimulus(8'd3, 1'b0);
        run_to_halt(cyc);
        check_output("p6_cycles", 32'(cyc), 32'd23);
        check_output("p6_acc", 32'(acc), 32'h07);
        check_output("p6_mdr_ld_count", 32'(n_mdr_ld), 32'd4);
        check_output("p6_ir_ld_count", 32'(n_ir_ld), 32'd2);
        check_output("p6_mem_rd_cycles", 32'(n_mem_rd), 32'd16);
        check_output("p6_mdr_ld_rule", 32'(n_bad_mdr), 32'd0);
        check_output("p6_err", 32'(err_o), 32'd0);

        // mem_ready_i stuck low: bus timeout after four strobe cycles.
        clear_prog();
        apply_stimulus(8'd0, 1'b1);
        run_to_halt(cyc);
        check_output("to_cycles", 32'(cyc), 32'd6);
        check_output("to_mem_rd_cycles", 32'(n_mem_rd), 32'd4);
        check_output("to_err", 32'(err_o), 32'd1);
        check_output("to_halted", 32'(halted_o), 32'd1);
        repeat (10) @(posedge clk_i);
        #1;
        check_output("to_stays_halt", 32'(state_o), 32'd12);
        check_output("to_strobe_dropped", 32'(mem_rd_o), 32'd0);
        rst_ni = 1'b0;
        #1;
        check_output("to_reset_clears_err", 32'({err_o, halted_o}), 32'd0);

        // Asynchronous reset while waiting in EM.
        clear_prog();
        prog[0] = 8'h10; prog[1] = 8'h11; prog[2] = 8'hF0; prog[8'h11] = 8'h07;
        apply_stimulus(8'd3, 1'b0);
        guard = 0;
        while (state_o != 4'd9 && guard < 50) begin
            @(posedge clk_i); #1; guard++;
        end
        check_output("ar_reached_em", 32'(state_o), 32'd9);
        #2;
        check_output("ar_em_strobe", 32'(mem_rd_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check_output("ar_state", 32'(state_o), 32'd0);
        check_output("ar_outputs", 32'(all_out), 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check_output("ar_restart_fa", 32'(state_o), 32'd1);
        check_output("ar_restart_mar_ld", 32'({mar_ld_o, mar_sel_o}), 32'b10);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Control unit of the 8-bit accumulator CPU.
- Sequences fetch/decode/execute and drives the ALU op code, register load enables and memory strobes for each instruction.
- Sits between the IR/flags registers (inputs) and the PC, MAR, MDR, ACC, flags registers, memory and ALU (outputs).
- Moore FSM, except for the memory-ready-qualified strobes.

Parameters:
- MEM_WAIT_MAX, 15: max cycles a memory strobe is held waiting for mem_ready_i before a bus-error halt. 0 disables the timeout. Legal range 0..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- run_i  in  1  level; leave IDLE and begin fetching when high.
- step_i  in  1  single-step pulse; used only with the optional feature.
- opcode_i  in  4  IR[7:4], valid from the cycle after ir_ld_o.
- flags_i  in  2  registered flags: [0] zero, [1] carry.
- mem_ready_i  in  1  memory completes the current read/write this cycle.
- alu_op_o  out  3  000 ADD, 001 SUB, 010 pass (LDA).
- acc_ld_o  out  1  load ACC from ALU result.
- flags_ld_o  out  1  load flags register from ALU flags.
- pc_inc_o  out  1  PC <= PC+1 (8-bit wrap, FF->00).
- pc_ld_o  out  1  PC <= MDR.
- mar_ld_o  out  1  load MAR.
- mar_sel_o  out  1  MAR source: 0 = PC, 1 = MDR.
- mem_rd_o  out  1  memory read strobe.
- mem_wr_o  out  1  memory write strobe (data = ACC).
- mdr_ld_o  out  1  MDR <= memory data; equals mem_rd_o & mem_ready_i.
- ir_ld_o  out  1  IR <= memory data.
- halted_o  out  1  FSM is in HALT.
- err_o  out  1  sticky bus-timeout error.
- state_o  out  4  current state encoding (debug).

Behaviour:
- Reset: state IDLE (0); all outputs 0; wait counter 0; err_o 0.
- IDLE: all strobes 0; run_i=1 -> FA.
- FA (fetch addr): mar_sel_o=0, mar_ld_o=1 -> FM.
- FM: mem_rd_o=1 held until mem_ready_i. On the ready cycle: ir_ld_o=1, pc_inc_o=1 -> DEC.
- DEC, by opcode_i:
  - 0 NOP -> FA.
  - 1 ADD, 2 SUB, 3 LDA, 4 STA, 5 JMP -> OA.
  - 6 JZ: -> OA if flags_i[0]=1, else SKIP.
  - 7 JC: -> OA if flags_i[1]=1, else SKIP.
  - F HLT -> HALT.
  - 8..E are illegal and behave as NOP.
- SKIP: pc_inc_o=1 (step over the operand byte) -> FA.
- OA: mar_sel_o=0, mar_ld_o=1 -> OM.
- OM: mem_rd_o=1 until ready. On ready: mdr_ld_o=1, pc_inc_o=1. Then jumps -> JMP; all others -> EA.
- JMP: pc_ld_o=1 -> FA.
- EA: mar_sel_o=1, mar_ld_o=1. STA -> WR; others -> EM.
- EM: mem_rd_o=1 until ready (mdr_ld_o) -> EX.
- EX: alu_op_o per opcode, acc_ld_o=1, flags_ld_o=1 -> FA. The ALU's y operand is MDR.
- WR: mem_wr_o=1 until ready -> FA. Flags are unchanged.
- HALT: halted_o=1; absorbing; left only by reset.
- alu_op_o is 000 in every state other than EX.
- Latency with mem_ready_i tied high:
  - NOP 3 cycles; not-taken jump 4; JMP / taken jump 6.
  - ADD/SUB/LDA 8; STA 7.
  - Each extra wait cycle adds 1.
- Timeout: a counter increments each cycle a strobe is high without ready and clears on ready or on state change. When MEM_WAIT_MAX>0 and the count reaches MEM_WAIT_MAX: drop the strobe, set err_o, go to HALT.
- run_i is sampled only in IDLE; deasserting it mid-instruction has no effect.
- Asynchronous reset mid-instruction returns to IDLE immediately, with all strobes 0 in the same cycle.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: completing an instruction (any transition into FA from DEC/SKIP/JMP/EX/WR) enters STEP_WAIT instead, with all strobes 0. A one-cycle step_i pulse -> FA.
- The first fetch after IDLE also waits for step_i.
- Undefined: STEP_WAIT does not exist and step_i is ignored.

Test Plan:
- Program {LDA 0x10; ADD 0x11; STA 0x12; HLT}, mem[10]=0x05, mem[11]=0x07, ready tied high -> mem[12]=0x0C; halted_o after 8+8+7+3 cycles from FA; err_o=0.
- SUB producing 0 (0x20-0x20): flags_ld_o pulses in EX -> zero flag=1. Following JZ 0x40 -> pc_ld_o pulses and PC=0x40. With zero=0, PC advances by 2 and no pc_ld_o occurs.
- mem_ready_i delayed 3 cycles on each access -> strobes held steady through the waits; ADD takes 8+9 cycles; one mdr_ld_o per access.
- MEM_WAIT_MAX=4, mem_ready_i stuck low in FM -> strobe drops after 4 cycles; err_o=1, halted_o=1; state stays HALT until reset.
- rst_ni low during EM -> all outputs 0 asynchronously; state_o=0; after release with run_i=1, fetch restarts at FA.
- With SINGLE_STEP_EN defined, NOP stream -> FSM stalls in STEP_WAIT after each NOP; each step_i pulse advances exactly one instruction (PC +1 per pulse).
